// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard-FSM state encoding, SRAM wait default
// and the register-match helper used by the hazard detector.
package pipeline_hazard_ctrl_pkg;

  localparam int unsigned SRAM_WAIT_DEFAULT = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // r0 is hard-wired zero, so a write to it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] dest,
                                     input logic [4:0] src1,
                                     input logic [4:0] src2,
                                     input logic       src2_valid);
    return (dest != 5'd0) && ((dest == src1) || ((dest == src2) && src2_valid));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-register fields seen by the hazard controller and the stall/flush
// controls it returns.
interface pipeline_hazard_ctrl_if;

  logic [4:0] id_src1;
  logic [4:0] id_src2;
  logic       id_src2_valid;
  logic [4:0] exe_dest;
  logic       exe_wb_en;
  logic       exe_mem_r_en;
  logic [4:0] mem_dest;
  logic       mem_wb_en;
  logic       mem_access;
  logic       br_taken;

  logic       stall;
  logic       loadForwardStall;
  logic       superStall;
  logic       Flush;
  logic       pc_freeze;
  logic       sram_ready;

  modport master (
    output id_src1, id_src2, id_src2_valid, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_access, br_taken,
    input  stall, loadForwardStall, superStall, Flush, pc_freeze, sram_ready
  );

  modport slave (
    input  id_src1, id_src2, id_src2_valid, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_access, br_taken,
    output stall, loadForwardStall, superStall, Flush, pc_freeze, sram_ready
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard detection; with forwarding only a load in EXE
// can still block the ID instruction.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter bit FORWARD_EN = 1'b1
) (
  input  logic [4:0] id_src1,
  input  logic [4:0] id_src2,
  input  logic       id_src2_valid,
  input  logic [4:0] exe_dest,
  input  logic       exe_wb_en,
  input  logic       exe_mem_r_en,
  input  logic [4:0] mem_dest,
  input  logic       mem_wb_en,
  output logic       haz
);

  logic exe_match;
  logic mem_match;

  always_comb begin
    exe_match = reg_match(exe_dest, id_src1, id_src2, id_src2_valid);
    mem_match = reg_match(mem_dest, id_src1, id_src2, id_src2_valid);
    if (FORWARD_EN) begin
      haz = exe_mem_r_en & exe_match;
    end else begin
      haz = (exe_wb_en & exe_match) | (mem_wb_en & mem_match);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: RAW stall, branch flush and SRAM superStall
// sequencing (IDLE -> WAIT -> DONE) around each MEM-stage access.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int unsigned SRAM_WAIT  = SRAM_WAIT_DEFAULT,
  parameter bit          FORWARD_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hif
);

  localparam logic [3:0] CNT_LOAD = 4'(SRAM_WAIT - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       haz;
  logic       super_stall, flush, stall_c, in_done, pc_freeze_c;

  hazard_detect #(.FORWARD_EN(FORWARD_EN)) u_hazard_detect (
    .id_src1       (hif.id_src1),
    .id_src2       (hif.id_src2),
    .id_src2_valid (hif.id_src2_valid),
    .exe_dest      (hif.exe_dest),
    .exe_wb_en     (hif.exe_wb_en),
    .exe_mem_r_en  (hif.exe_mem_r_en),
    .mem_dest      (hif.mem_dest),
    .mem_wb_en     (hif.mem_wb_en),
    .haz           (haz)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hif.mem_access) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
        else             state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // pc_freeze is masked by Flush: the DONE cycle may carry a deferred branch
  // flush, and the PC must then take the branch target rather than hold.
  always_comb begin
    in_done     = (state_q == ST_DONE);
    super_stall = ((state_q == ST_IDLE) & hif.mem_access) | (state_q == ST_WAIT);
    flush       = hif.br_taken & ~super_stall;
    stall_c     = haz & ~flush & ~super_stall & ~in_done;
    pc_freeze_c = (stall_c | super_stall | in_done) & ~flush;

    hif.stall            = ~rst & stall_c;
    hif.loadForwardStall = ~rst & in_done;
    hif.superStall       = ~rst & super_stall;
    hif.Flush            = ~rst & flush;
    hif.pc_freeze        = ~rst & pc_freeze_c;
    hif.sram_ready       = ~rst & in_done;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: one forwarding instance (SRAM_WAIT=5) and one without
// forwarding (SRAM_WAIT=1); outputs packed {stall,lfs,ss,flush,pcf,rdy}.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hif_a ();
  pipeline_hazard_ctrl_if hif_b ();

  pipeline_hazard_ctrl #(.SRAM_WAIT(5), .FORWARD_EN(1'b1)) u_dut_a (
    .clk (clk), .rst (rst), .hif (hif_a.slave)
  );
  pipeline_hazard_ctrl #(.SRAM_WAIT(1), .FORWARD_EN(1'b0)) u_dut_b (
    .clk (clk), .rst (rst), .hif (hif_b.slave)
  );

  logic [5:0] out_a, out_b;
  assign out_a = {hif_a.stall, hif_a.loadForwardStall, hif_a.superStall,
                  hif_a.Flush, hif_a.pc_freeze, hif_a.sram_ready};
  assign out_b = {hif_b.stall, hif_b.loadForwardStall, hif_b.superStall,
                  hif_b.Flush, hif_b.pc_freeze, hif_b.sram_ready};

  localparam logic [5:0] O_NONE  = 6'b000000;
  localparam logic [5:0] O_STALL = 6'b100010;
  localparam logic [5:0] O_SS    = 6'b001010;
  localparam logic [5:0] O_DONE  = 6'b010011;
  localparam logic [5:0] O_DONEF = 6'b010101;
  localparam logic [5:0] O_FLUSH = 6'b000100;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr_a();
    hif_a.id_src1 = '0; hif_a.id_src2 = '0; hif_a.id_src2_valid = 1'b0;
    hif_a.exe_dest = '0; hif_a.exe_wb_en = 1'b0; hif_a.exe_mem_r_en = 1'b0;
    hif_a.mem_dest = '0; hif_a.mem_wb_en = 1'b0; hif_a.mem_access = 1'b0;
    hif_a.br_taken = 1'b0;
  endtask

  task automatic clr_b();
    hif_b.id_src1 = '0; hif_b.id_src2 = '0; hif_b.id_src2_valid = 1'b0;
    hif_b.exe_dest = '0; hif_b.exe_wb_en = 1'b0; hif_b.exe_mem_r_en = 1'b0;
    hif_b.mem_dest = '0; hif_b.mem_wb_en = 1'b0; hif_b.mem_access = 1'b0;
    hif_b.br_taken = 1'b0;
  endtask

  initial begin
    clr_a(); clr_b();
    // Reset with busy inputs: outputs must be forced low.
    rst = 1'b1;
    hif_a.mem_access = 1'b1; hif_a.br_taken = 1'b1;
    hif_a.exe_mem_r_en = 1'b1; hif_a.exe_dest = 5'd5; hif_a.id_src1 = 5'd5;
    hif_b.br_taken = 1'b1;
    settle(); chk("rst_a_forced", out_a, O_NONE); chk("rst_b_forced", out_b, O_NONE);
    tick(); tick();
    rst = 1'b0; clr_a(); clr_b();
    settle(); chk("idle_a", out_a, O_NONE); chk("idle_b", out_b, O_NONE);

    // Forwarding instance: only a load in EXE stalls.
    hif_a.exe_mem_r_en = 1'b1; hif_a.exe_dest = 5'd5; hif_a.id_src1 = 5'd5;
    settle(); chk("fwd_load_use", out_a, O_STALL);
    hif_a.exe_dest = 5'd0; hif_a.id_src1 = 5'd0;
    settle(); chk("fwd_dest_r0", out_a, O_NONE);
    hif_a.exe_mem_r_en = 1'b0; hif_a.exe_wb_en = 1'b1; hif_a.exe_dest = 5'd9; hif_a.id_src1 = 5'd9;
    settle(); chk("fwd_alu_no_stall", out_a, O_NONE);
    clr_a();
    hif_a.exe_mem_r_en = 1'b1; hif_a.exe_dest = 5'd12; hif_a.id_src2 = 5'd12;
    settle(); chk("fwd_src2_imm", out_a, O_NONE);
    hif_a.id_src2_valid = 1'b1;
    settle(); chk("fwd_src2_valid", out_a, O_STALL);
    hif_a.br_taken = 1'b1;
    settle(); chk("fwd_flush_over_stall", out_a, O_FLUSH);
    tick(); clr_a();

    // Single access: 6 superStall cycles, then one DONE cycle, then IDLE.
    hif_a.mem_access = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle(); chk("ss_run", out_a, O_SS);
      tick(); hif_a.mem_access = 1'b0;
    end
    settle(); chk("ss_done", out_a, O_DONE);
    tick(); settle(); chk("ss_back_idle", out_a, O_NONE);

    // Branch and load-use hazard held across an access; mem_access kept high.
    hif_a.mem_access = 1'b1; hif_a.br_taken = 1'b1;
    hif_a.exe_mem_r_en = 1'b1; hif_a.exe_dest = 5'd3; hif_a.id_src1 = 5'd3;
    for (int i = 0; i < 6; i++) begin
      settle(); chk("br_hold_frozen", out_a, O_SS);
      tick();
    end
    settle(); chk("br_flush_in_done", out_a, O_DONEF);
    tick(); settle(); chk("back_to_back_restart", out_a, O_SS);
    tick(); tick(); tick();
    // Now in WAIT with cnt=2.
    rst = 1'b1;
    settle(); chk("rst_mid_wait_forced", out_a, O_NONE);
    tick(); rst = 1'b0; clr_a();
    settle(); chk("post_rst_idle", out_a, O_NONE);
    hif_a.mem_access = 1'b1;
    for (int i = 0; i < 6; i++) begin
      settle(); chk("post_rst_ss", out_a, O_SS);
      tick(); hif_a.mem_access = 1'b0;
    end
    settle(); chk("post_rst_done", out_a, O_DONE);
    tick(); settle(); chk("post_rst_idle2", out_a, O_NONE);

    // No-forwarding instance.
    hif_b.mem_wb_en = 1'b1; hif_b.mem_dest = 5'd7; hif_b.id_src2 = 5'd7;
    settle(); chk("nofwd_src2_imm", out_b, O_NONE);
    hif_b.id_src2_valid = 1'b1;
    settle(); chk("nofwd_mem_src2", out_b, O_STALL);
    clr_b();
    hif_b.exe_wb_en = 1'b1; hif_b.exe_dest = 5'd3; hif_b.id_src1 = 5'd3;
    settle(); chk("nofwd_exe_src1", out_b, O_STALL);
    hif_b.exe_wb_en = 1'b0; hif_b.exe_mem_r_en = 1'b1;
    settle(); chk("nofwd_load_no_wb", out_b, O_NONE);
    clr_b();
    hif_b.mem_wb_en = 1'b1; hif_b.mem_dest = 5'd0;
    settle(); chk("nofwd_dest_r0", out_b, O_NONE);
    clr_b();

    // SRAM_WAIT=1 boundary: two superStall cycles.
    hif_b.mem_access = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle(); chk("w1_ss", out_b, O_SS);
      tick(); hif_b.mem_access = 1'b0;
    end
    hif_b.mem_access = 1'b1;
    settle(); chk("w1_done_ignores_access", out_b, O_DONE);
    tick(); settle(); chk("w1_restart", out_b, O_SS);
    tick(); hif_b.mem_access = 1'b0;
    settle(); chk("w1_wait", out_b, O_SS);
    tick(); settle(); chk("w1_done2", out_b, O_DONE);
    tick(); settle(); chk("w1_idle", out_b, O_NONE);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
